// File: rtl/load_store_unit.sv
// load_store_unit
// Initiator side of the core data bus. Takes one load/store request at a
// time from the execute stage, issues aligned 64-bit cell accesses, and
// returns extended load data or a fault cause over a valid/ready channel.
// Stores narrower than a cell are done as read-modify-write because the
// bus only writes whole 8-byte cells.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_*               request channel (valid/ready, we, funct3, addr, wdata)
//   resp_*              response channel (valid/ready, rdata, fault, cause)
//   bus_rw/addr/write   registered bus command (1 = write cycle)
//   bus_read/exception  combinational reply from data_bus for bus_addr
module load_store_unit #(
    parameter int bus_width   = 3,
    parameter int cause_width = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [2:0]             req_funct3,
    input  logic [63:0]            req_addr,
    input  logic [63:0]            req_wdata,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [63:0]            resp_rdata,
    output logic                   resp_fault,
    output logic [cause_width-1:0] resp_cause,
    output logic                   bus_rw,
    output logic [63:0]            bus_addr,
    output logic [63:0]            bus_write,
    input  logic [63:0]            bus_read,
    input  logic                   bus_exception
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } state_t;

    localparam logic [cause_width-1:0] CAUSE_NONE        = cause_width'(0);
    localparam logic [cause_width-1:0] CAUSE_ILLEGAL     = cause_width'(2);
    localparam logic [cause_width-1:0] CAUSE_LD_MISALIGN = cause_width'(4);
    localparam logic [cause_width-1:0] CAUSE_LD_ACCESS   = cause_width'(5);
    localparam logic [cause_width-1:0] CAUSE_ST_MISALIGN = cause_width'(6);
    localparam logic [cause_width-1:0] CAUSE_ST_ACCESS   = cause_width'(7);

    state_t                 state_q, state_d;
    logic                   we_q, we_d;
    logic [2:0]             funct3_q, funct3_d;
    logic [bus_width-1:0]   lane_q, lane_d;
    logic [63:0]            wdata_q, wdata_d;
    logic                   req_ready_q, req_ready_d;
    logic                   resp_valid_q, resp_valid_d;
    logic [63:0]            resp_rdata_q, resp_rdata_d;
    logic                   resp_fault_q, resp_fault_d;
    logic [cause_width-1:0] resp_cause_q, resp_cause_d;
    logic                   bus_rw_q, bus_rw_d;
    logic [63:0]            bus_addr_q, bus_addr_d;
    logic [63:0]            bus_write_q, bus_write_d;

    logic [bus_width+2:0]   lane_shift;
    logic [63:0]            shifted_read;
    logic [63:0]            load_data;
    logic [63:0]            size_mask;
    logic [63:0]            store_merge;
    logic                   req_illegal;
    logic                   req_misaligned;

    // Datapath helpers: lane extraction for loads and byte merge for
    // sub-doubleword stores, both driven from the captured request.
    always_comb begin
        lane_shift   = {lane_q, 3'b000};
        shifted_read = bus_read >> lane_shift;
        load_data    = shifted_read;
        size_mask    = '1;
        case (funct3_q[1:0])
            2'b00: begin
                size_mask = 64'h0000_0000_0000_00FF;
                load_data = funct3_q[2] ? {56'b0, shifted_read[7:0]}
                                        : {{56{shifted_read[7]}}, shifted_read[7:0]};
            end
            2'b01: begin
                size_mask = 64'h0000_0000_0000_FFFF;
                load_data = funct3_q[2] ? {48'b0, shifted_read[15:0]}
                                        : {{48{shifted_read[15]}}, shifted_read[15:0]};
            end
            2'b10: begin
                size_mask = 64'h0000_0000_FFFF_FFFF;
                load_data = funct3_q[2] ? {32'b0, shifted_read[31:0]}
                                        : {{32{shifted_read[31]}}, shifted_read[31:0]};
            end
            default: begin
                size_mask = '1;
                load_data = shifted_read;
            end
        endcase
        store_merge = (bus_read & ~(size_mask << lane_shift))
                    | ((wdata_q & size_mask) << lane_shift);
    end

    // Pre-checks on the incoming request; illegal size outranks misalignment.
    always_comb begin
        req_illegal    = (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
        req_misaligned = 1'b0;
        case (req_funct3[1:0])
            2'b01:   req_misaligned = req_addr[0];
            2'b10:   req_misaligned = (req_addr[1:0] != 2'b00);
            2'b11:   req_misaligned = (req_addr[2:0] != 3'b000);
            default: req_misaligned = 1'b0;
        endcase
    end

    // Next-state and registered-output logic for the access sequencer.
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_fault_d = resp_fault_q;
        resp_cause_d = resp_cause_q;
        bus_rw_d     = bus_rw_q;
        bus_addr_d   = bus_addr_q;
        bus_write_d  = bus_write_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    we_d        = req_we;
                    funct3_d    = req_funct3;
                    lane_d      = req_addr[bus_width-1:0];
                    wdata_d     = req_wdata;
                    bus_addr_d  = {req_addr[63:bus_width], {bus_width{1'b0}}};
                    req_ready_d = 1'b0;
                    if (req_illegal || req_misaligned) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_fault_d = 1'b1;
                        resp_rdata_d = '0;
                        if (req_illegal) begin
                            resp_cause_d = CAUSE_ILLEGAL;
                        end else begin
                            resp_cause_d = req_we ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
                        end
                    end else if (req_we && (req_funct3[1:0] == 2'b11)) begin
                        // Full-cell store needs no read, go straight to the write.
                        state_d     = ST_WRITE;
                        bus_rw_d    = 1'b1;
                        bus_write_d = req_wdata;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end

            ST_READ: begin
                if (bus_exception) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_fault_d = 1'b1;
                    resp_rdata_d = '0;
                    resp_cause_d = we_q ? CAUSE_ST_ACCESS : CAUSE_LD_ACCESS;
                end else if (we_q) begin
                    state_d     = ST_WRITE;
                    bus_rw_d    = 1'b1;
                    bus_write_d = store_merge;
                end else begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_fault_d = 1'b0;
                    resp_rdata_d = load_data;
                    resp_cause_d = CAUSE_NONE;
                end
            end

            ST_WRITE: begin
                state_d      = ST_RESP;
                bus_rw_d     = 1'b0;
                resp_valid_d = 1'b1;
                resp_rdata_d = '0;
                resp_fault_d = bus_exception;
                resp_cause_d = bus_exception ? CAUSE_ST_ACCESS : CAUSE_NONE;
            end

            ST_RESP: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    req_ready_d  = 1'b1;
                    resp_valid_d = 1'b0;
                    resp_rdata_d = '0;
                    resp_fault_d = 1'b0;
                    resp_cause_d = CAUSE_NONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset abandons any in-flight access without a response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            funct3_q     <= 3'b000;
            lane_q       <= '0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_fault_q <= 1'b0;
            resp_cause_q <= CAUSE_NONE;
            bus_rw_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_write_q  <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            lane_q       <= lane_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_fault_q <= resp_fault_d;
            resp_cause_q <= resp_cause_d;
            bus_rw_q     <= bus_rw_d;
            bus_addr_q   <= bus_addr_d;
            bus_write_q  <= bus_write_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_fault = resp_fault_q;
    assign resp_cause = resp_cause_q;
    assign bus_rw     = bus_rw_q;
    assign bus_addr   = bus_addr_q;
    assign bus_write  = bus_write_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
// Drives load_store_unit against a small data_bus model (16 cells at
// 0x1000, everything else raises bus_exception) and compares every
// response with a byte-level reference model of memory.
module tb_load_store_unit;

    localparam logic [63:0] BASE   = 64'h1000;
    localparam int          NCELLS = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_fault;
    logic [3:0]  resp_cause;
    logic        bus_rw;
    logic [63:0] bus_addr;
    logic [63:0] bus_write;
    logic [63:0] bus_read;
    logic        bus_exception;

    logic [63:0] cells      [NCELLS];
    logic [63:0] init_cells [NCELLS];
    logic [7:0]  ref_bytes  [NCELLS*8];
    logic        load_init;
    logic        in_range;

    int compared   = 0;
    int mismatched = 0;
    int rw_cycles  = 0;

    always #5 clk = ~clk;

    load_store_unit #(.bus_width(3), .cause_width(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .resp_fault    (resp_fault),
        .resp_cause    (resp_cause),
        .bus_rw        (bus_rw),
        .bus_addr      (bus_addr),
        .bus_write     (bus_write),
        .bus_read      (bus_read),
        .bus_exception (bus_exception)
    );

    // data_bus model: combinational read and range flag, write on the edge.
    always_comb begin
        in_range      = (bus_addr >= BASE) && (bus_addr < BASE + 64'(NCELLS*8));
        bus_exception = !in_range;
        bus_read      = in_range ? cells[bus_addr[6:3]] : 64'hDEAD_BEEF_0BAD_F00D;
    end

    always @(posedge clk) begin
        if (load_init) begin
            for (int i = 0; i < NCELLS; i++) cells[i] <= init_cells[i];
        end else if (bus_rw && in_range) begin
            cells[bus_addr[6:3]] <= bus_write;
        end
    end

    // Counts cycles in which a write command is on the bus.
    always @(negedge clk) begin
        if (bus_rw === 1'b1) rw_cycles++;
    end

    // Watchdog so the run always ends even if the DUT wedges.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] refCell(input logic [63:0] addr);
        logic [63:0] v;
        int          base_off;
        v        = '0;
        base_off = int'(addr[6:3]) * 8;
        for (int i = 0; i < 8; i++) v |= 64'(ref_bytes[base_off+i]) << (8*i);
        return v;
    endfunction

    // Reference model: RV64 load/store semantics on a flat byte memory.
    task automatic refModel(input logic we, input logic [2:0] f3,
                            input logic [63:0] addr, input logic [63:0] wdata,
                            output logic ef, output logic [3:0] ec,
                            output logic [63:0] er, output int el, output int ew);
        int          size;
        int          off;
        logic [63:0] v;
        size = 1 << f3[1:0];
        ef   = 1'b1;
        ec   = 4'd0;
        er   = '0;
        el   = 1;
        ew   = 0;
        if (f3 == 3'b111 || (we && f3[2])) begin
            ec = 4'd2;
        end else if ((addr % 64'(size)) != 0) begin
            ec = we ? 4'd6 : 4'd4;
        end else if (addr < BASE || addr >= BASE + 64'(NCELLS*8)) begin
            ec = we ? 4'd7 : 4'd5;
            el = 2;
            if (we && size == 8) ew = 1;
        end else begin
            off = int'(addr - BASE);
            ef  = 1'b0;
            if (!we) begin
                v = '0;
                for (int i = 0; i < size; i++) v |= 64'(ref_bytes[off+i]) << (8*i);
                if (!f3[2] && size < 8 && v[8*size-1]) v |= ~((64'd1 << (8*size)) - 64'd1);
                er = v;
                el = 2;
            end else begin
                for (int i = 0; i < size; i++) ref_bytes[off+i] = wdata[8*i +: 8];
                el = (size == 8) ? 2 : 3;
                ew = 1;
            end
        end
    endtask

    // One complete transaction: request, response wait, optional
    // backpressure of `hold` cycles, then the response handshake.
    task automatic applyStimulus(input logic we, input logic [2:0] f3,
                                 input logic [63:0] addr, input logic [63:0] wdata,
                                 input int hold);
        logic        ef;
        logic [3:0]  ec;
        logic [63:0] er;
        int          el, ew, lat, rw0;
        logic [63:0] snap_rdata;
        logic        snap_fault;
        logic [3:0]  snap_cause;
        refModel(we, f3, addr, wdata, ef, ec, er, el, ew);
        @(negedge clk);
        checkOutput("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        rw0        = rw_cycles;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = {$urandom, $urandom};
        req_wdata  = {$urandom, $urandom};
        while (resp_valid !== 1'b1 && lat < 12) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checkOutput("latency", 64'(lat), 64'(el));
        checkOutput("resp_fault", 64'(resp_fault), 64'(ef));
        checkOutput("resp_cause", 64'(resp_cause), 64'(ec));
        checkOutput("resp_rdata", resp_rdata, er);
        checkOutput("bus_rw_cycles", 64'(rw_cycles - rw0), 64'(ew));
        checkOutput("bus_addr", bus_addr, {addr[63:3], 3'b000});
        checkOutput("req_ready_busy", 64'(req_ready), 64'd0);
        snap_rdata = resp_rdata;
        snap_fault = resp_fault;
        snap_cause = resp_cause;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("hold_valid", 64'(resp_valid), 64'd1);
            checkOutput("hold_rdata", resp_rdata, snap_rdata);
            checkOutput("hold_fault", 64'(resp_fault), 64'(snap_fault));
            checkOutput("hold_cause", 64'(resp_cause), 64'(snap_cause));
            checkOutput("hold_req_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        checkOutput("done_valid", 64'(resp_valid), 64'd0);
        checkOutput("done_rdata", resp_rdata, 64'd0);
        checkOutput("done_fault", 64'(resp_fault), 64'd0);
        checkOutput("done_cause", 64'(resp_cause), 64'd0);
        checkOutput("done_req_ready", 64'(req_ready), 64'd1);
        checkOutput("done_bus_rw", 64'(bus_rw), 64'd0);
        if (addr >= BASE && addr < BASE + 64'(NCELLS*8))
            checkOutput("mem_cell", cells[addr[6:3]], refCell(addr));
    endtask

    // Directed steps from the test plan, then a randomized sweep.
    initial begin
        logic        rwe;
        logic [2:0]  rf3;
        logic [63:0] raddr;
        int          wait_cnt;

        rst        = 1'b1;
        load_init  = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < NCELLS; i++) init_cells[i] = {$urandom, $urandom};
        init_cells[0] = 64'h8877_6655_4433_2211;
        for (int i = 0; i < NCELLS; i++)
            for (int b = 0; b < 8; b++) ref_bytes[i*8+b] = init_cells[i][8*b +: 8];
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        load_init = 1'b0;

        checkOutput("rst_req_ready", 64'(req_ready), 64'd1);
        checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("rst_resp_rdata", resp_rdata, 64'd0);
        checkOutput("rst_resp_fault", 64'(resp_fault), 64'd0);
        checkOutput("rst_resp_cause", 64'(resp_cause), 64'd0);
        checkOutput("rst_bus_rw", 64'(bus_rw), 64'd0);
        checkOutput("rst_bus_addr", bus_addr, 64'd0);
        checkOutput("rst_bus_write", bus_write, 64'd0);

        applyStimulus(1'b0, 3'b000, 64'h1007, 64'd0, 0);
        applyStimulus(1'b0, 3'b100, 64'h1007, 64'd0, 0);
        applyStimulus(1'b1, 3'b001, 64'h1002, 64'hABCD, 0);
        checkOutput("sh_cell_const", cells[0], 64'h8877_6655_ABCD_2211);
        applyStimulus(1'b0, 3'b010, 64'h1002, 64'd0, 0);
        applyStimulus(1'b1, 3'b011, 64'h1004, 64'd0, 0);
        applyStimulus(1'b0, 3'b111, 64'h1000, 64'd0, 0);
        applyStimulus(1'b1, 3'b100, 64'h1000, 64'd0, 0);
        applyStimulus(1'b1, 3'b000, 64'h2001, 64'h55, 0);
        applyStimulus(1'b0, 3'b011, 64'h2000, 64'd0, 0);
        applyStimulus(1'b0, 3'b010, 64'h1004, 64'd0, 5);
        applyStimulus(1'b0, 3'b011, 64'h1000, 64'd0, 1);

        // Reset while a full-cell store sits in its write cycle.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b011;
        req_addr   = 64'h2000;
        req_wdata  = 64'h1234_5678_9ABC_DEF0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("pre_rst_bus_rw", 64'(bus_rw), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mid_rst_bus_rw", 64'(bus_rw), 64'd0);
        checkOutput("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("mid_rst_req_ready", 64'(req_ready), 64'd1);
        wait_cnt = 0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            if (resp_valid !== 1'b0) wait_cnt++;
        end
        checkOutput("mid_rst_no_resp", 64'(wait_cnt), 64'd0);

        for (int n = 0; n < 60; n++) begin
            rwe = 1'($urandom_range(0, 1));
            rf3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 5) == 0) raddr = 64'h2000 + 64'($urandom_range(0, 63));
            else                           raddr = BASE + 64'($urandom_range(0, 127));
            if ($urandom_range(0, 1) == 0 && rf3 != 3'b111) raddr[1:0] = 2'b00;
            applyStimulus(rwe, rf3, raddr, {$urandom, $urandom}, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the core data bus: accepts one load/store request at a time from the execute stage and issues aligned 64-bit cell accesses to data_bus.
- Loads: extracts bytes, sign/zero-extends.
- Sub-doubleword stores: read-modify-write, since the bus only writes whole 8-byte cells.
- Returns data or a fault cause to the pipeline over a valid/ready response channel.

Parameters:
- bus_width, 3: log2 of bytes per bus cell; fixed at 3 for the 64-bit bus. The aligned address is addr with the low bus_width bits cleared.
- cause_width, 4: width of the resp_cause field.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request; high only in IDLE
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RV64 size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU, 111 illegal
- req_addr  input  64  byte address
- req_wdata  input  64  store data, right-justified
- resp_valid  output  1  response present
- resp_ready  input  1  pipeline consumes response
- resp_rdata  output  64  extended load data; 0 for stores and faults
- resp_fault  output  1  access faulted
- resp_cause  output  cause_width  fault cause; 0 when no fault
- bus_rw  output  1  1 = write cycle to data_bus
- bus_addr  output  64  aligned cell address
- bus_write  output  64  full cell write data
- bus_read  input  64  cell read data; combinational from data_bus in the same cycle
- bus_exception  input  1  out-of-range flag for the current bus_addr; combinational

Behaviour:
- **Clocking and reset:** one clock; reset is synchronous and active-high. All outputs are registered.
- **Reset values:** state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_fault = 0, resp_cause = 0, bus_rw = 0, bus_addr = 0, bus_write = 0.
- **Reset mid-operation:** rst has priority in every state. An in-flight access is abandoned with no response, and bus_rw is 0 from the next edge.
- **Request capture:** a handshake occurs when req_valid and req_ready are both high in IDLE. The unit captures we, funct3, addr, wdata and lane = addr[2:0]. bus_addr is loaded with the aligned address on the same edge.
- **Pre-checks at capture, in priority order:**
  1. Illegal size (funct3 = 111, or a store with funct3[2] = 1) -> RESP, cause 2.
  2. Misaligned (H with addr[0] set; W with addr[1:0] nonzero; D with addr[2:0] nonzero) -> RESP, cause 4 for load, 6 for store.
  - No bus cycle is issued for either.
- **Next state after a clean capture:** load -> READ; store D -> WRITE, with bus_write = wdata; store B/H/W -> READ.
- **IDLE:** req_ready = 1. Leaving IDLE drives req_ready low on the same edge.
- **READ:** bus_rw = 0; bus_read and bus_exception are sampled at the end of the cycle.
  - bus_exception = 1 -> RESP, cause 5 for load, 7 for store; no write is issued.
  - Load -> extract the lane bytes (byte at lane*8, half at lane*8, word at lane*8) and sign-extend for B/H/W or zero-extend for BU/HU/WU; D passes through. Then go to RESP.
  - Store -> merge wdata's low 1/2/4 bytes into bus_read at the lane, leaving other bytes unchanged, into bus_write; go to WRITE.
- **WRITE:** bus_rw = 1 for exactly one cycle.
  - bus_exception sampled -> fault cause 7 if set, else success.
  - Next state is RESP; bus_rw returns to 0 on that edge.
- **RESP:** resp_valid = 1; resp_rdata, resp_fault and resp_cause are held stable until resp_ready.
  - When resp_ready is seen, the next edge goes to IDLE: resp_valid = 0, resp_rdata/resp_fault/resp_cause cleared to 0.
  - No back-to-back acceptance in that cycle.
- **Latency (accept edge = T):**
  - load / store D: resp_valid at T+2
  - store B/H/W: resp_valid at T+3
  - pre-check fault: resp_valid at T+1
- **Bus quiescence:** bus_addr holds its value outside READ/WRITE. bus_write is meaningful only when bus_rw = 1. A read cycle never coincides with a write cycle.
- **Address wrap:** none. Bus range checking belongs to data_bus and is reported via bus_exception.

Test Plan:
- Load byte, negative: bus cell at 0x1000 = 0x8877665544332211, LB addr 0x1007 -> bus_addr 0x1000, resp_rdata 0xFFFFFFFFFFFFFF88 at T+2, fault 0.
- Load byte, unsigned: same cell, LBU addr 0x1007 -> resp_rdata 0x0000000000000088.
- Halfword store: cell 0x1000 = 0x8877665544332211, SH addr 0x1002 wdata 0xABCD -> one read then one write with bus_write 0x88776655ABCD2211, bus_rw high exactly one cycle, response at T+3.
- Misaligned / illegal: LW addr 0x1002 -> resp_fault 1, cause 4, no bus_rw pulse, response at T+1. SD addr 0x1004 -> cause 6. funct3 111 -> cause 2.
- Bus exception: SB to an address where data_bus raises bus_exception during READ -> cause 7, bus_rw never asserted. LD to the same address -> cause 5, resp_rdata 0.
- Backpressure and reset: hold resp_ready = 0 for 5 cycles -> outputs stable, req_ready 0. Assert rst during WRITE -> next edge: IDLE, bus_rw 0, resp_valid 0, req_ready 1.
